qspi_xfer_arbiter: RTL and testbench
====================================

Name: qspi_xfer_arbiter

Overview:
- Schedules the single QSPI engine (qspi_cont + qspi_datapath) between two requesters:
  - XIP read sequences raised by the AHB slave controller.
  - Indirect-mode transfers raised from the indirect command/address registers.
- Issues one-cycle start/break commands to the engine and tracks engine busy/done.
- Enforces anti-starvation for indirect requests and a watchdog timeout on hung transfers.
- Sits between slave_controller and qspi_cont, replacing direct start wiring.

Parameters:
- TIMEOUT_W, 16: width of the watchdog counter and of timeout_lim_in.
- STARVE_LIM, 4: maximum consecutive XIP grants while ind_req is pending; the next arbitration after that grants indirect.

Ports:
- h_clk  input  1  system clock.
- h_rstn  input  1  reset, synchronous, active-low.
- xip_req_in  input  1  level; XIP sequence wanted.
- xip_break_in  input  1  pulse; abort the current XIP sequence (AHB non-seq/idle break).
- ind_req_in  input  1  level; indirect transfer wanted.
- ind_wr_in  input  1  indirect direction; 1 = write. Sampled at grant.
- eng_busy_in  input  1  engine busy (qspi_busy).
- eng_done_in  input  1  pulse; engine finished the sequence (set_done_flag).
- timeout_lim_in  input  TIMEOUT_W  watchdog limit in h_clk cycles; 0 disables the watchdog.
- err_clr_in  input  1  clears timeout_err_out.
- start_xip_out  output  1  one-cycle start to the engine (start_new_xip_seq).
- start_ind_out  output  1  one-cycle start to the engine (start_indrct_mode).
- ind_wr_out  output  1  direction latched at indirect grant.
- break_seq_out  output  1  one-cycle break to the engine.
- xip_gnt_out  output  1  XIP owns the engine.
- ind_gnt_out  output  1  indirect owns the engine.
- xip_ack_out  output  1  pulse; XIP sequence completed normally.
- ind_ack_out  output  1  pulse; indirect transfer completed normally.
- timeout_err_out  output  1  sticky watchdog error.

Behaviour:
- Reset (h_rstn low at a rising edge):
  - State goes to IDLE.
  - All outputs 0; starve_cnt 0; wdog 0.
  - Reset mid-transfer abandons the transfer; no break is issued.
- States: IDLE, XIP_START, XIP_ACT, IND_START, IND_ACT, ABORT.
- IDLE:
  - If ind_req_in and (!xip_req_in or starve_cnt == STARVE_LIM), go to IND_START. Latch ind_wr_out and clear starve_cnt.
  - Else if xip_req_in, go to XIP_START. If ind_req_in, increment starve_cnt, saturating at STARVE_LIM.
  - Else stay in IDLE.
- XIP_START:
  - start_xip_out = 1 in the first cycle only.
  - Wait for eng_busy_in = 1, then go to XIP_ACT.
- XIP_ACT:
  - eng_done_in = 1: xip_ack_out pulses and the state goes to IDLE.
  - Else if xip_break_in = 1: break_seq_out pulses and the state goes to ABORT.
  - If done and break arrive in the same cycle, done wins and the break is dropped.
- IND_START and IND_ACT:
  - Same pattern as the XIP path, using start_ind_out and ind_ack_out.
  - xip_break_in is ignored during indirect.
  - ind_req_in deasserting after grant does not cancel the transfer.
- ABORT:
  - Wait for eng_busy_in = 0, then go to IDLE.
  - No ack is issued.
- Grants:
  - xip_gnt_out = 1 in XIP_START and XIP_ACT, and in ABORT when the aborted sequence was XIP.
  - ind_gnt_out = 1 in IND_START and IND_ACT.
  - The two grants are never high together.
  - Grant outputs are registered, so a grant is visible one cycle after the IDLE decision.
- Minimum turnaround: at least 1 IDLE cycle between consecutive grants.
- Watchdog:
  - wdog counts every cycle outside IDLE and clears on entry to IDLE.
  - When timeout_lim_in != 0 and wdog == timeout_lim_in - 1:
    - timeout_err_out is set.
    - break_seq_out pulses.
    - State goes to IDLE without an ack.
  - A timeout has priority over done/break in the same cycle.
- Error clear: err_clr_in clears timeout_err_out; if a timeout fires in the same cycle, set wins.
- eng_done_in outside the ACT states is ignored.
- Arithmetic: wdog is TIMEOUT_W bits wide and never wraps, because the limit is checked before increment. starve_cnt is $clog2(STARVE_LIM+1) bits wide.

Decomposition:
- Package qspi_arb_pkg:
  - arb_state_t enum with the six states.
  - Owner encoding constants OWN_NONE, OWN_XIP, OWN_IND.
- One sub-module: qspi_arb_wdog. It holds the counter, the limit compare and the sticky error, and takes an enable, a clear and the limit as inputs.

Test Plan:
- XIP only: xip_req pulse; engine raises busy 2 cycles later, then done at cycle 10.
  - Expect start_xip_out for exactly 1 cycle and xip_gnt_out high until done.
  - Expect xip_ack_out one-cycle pulse and return to IDLE.
- Both requesters held continuously, STARVE_LIM=4:
  - Expect grant order X,X,X,X,I,X,X,X,X,I.
  - Expect ind_wr_out to equal ind_wr_in at each indirect grant.
- XIP break: xip_break_in at cycle 5 of XIP_ACT, busy drops 3 cycles later.
  - Expect a single break_seq_out pulse, no xip_ack_out, and IDLE after busy falls.
- Done and break in the same cycle: expect xip_ack_out = 1 and break_seq_out = 0.
- Watchdog with timeout_lim_in = 20 and engine never signalling done:
  - Expect break_seq_out 20 cycles after grant, timeout_err_out = 1, and IDLE.
  - err_clr_in then clears the error.
  - Repeat with timeout_lim_in = 0: no timeout ever fires.
- Reset mid-IND_ACT: assert h_rstn = 0 for 1 cycle.
  - Expect all outputs 0 at the next edge, state IDLE, and no break issued.

Source files
------------

// File: rtl/qspi_xfer_arbiter_pkg.sv
// Shared types for the QSPI transfer arbiter: FSM states, owner encoding
// and small decode helpers used by the top level.
package qspi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XIP_START,
    ST_XIP_ACT,
    ST_IND_START,
    ST_IND_ACT,
    ST_ABORT
  } arb_state_t;

  // Who holds the engine; needed so ABORT knows which grant to keep high.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_XIP  = 2'd1;
  localparam logic [1:0] OWN_IND  = 2'd2;

  // XIP owns the engine while starting, active, or draining an XIP abort.
  function automatic logic xip_owned(arb_state_t s, logic [1:0] owner);
    return (s == ST_XIP_START) || (s == ST_XIP_ACT) ||
           ((s == ST_ABORT) && (owner == OWN_XIP));
  endfunction

  // Indirect owns the engine while starting or active.
  function automatic logic ind_owned(arb_state_t s);
    return (s == ST_IND_START) || (s == ST_IND_ACT);
  endfunction

endpackage

// File: rtl/qspi_xfer_arbiter_if.sv
// Requester/engine handshake bundle for the QSPI transfer arbiter.
// master = requesters + engine side, slave = the arbiter itself.
interface qspi_xfer_arbiter_if #(parameter int TIMEOUT_W = 16);

  // Requests and engine status towards the arbiter
  logic                 xip_req_in;
  logic                 xip_break_in;
  logic                 ind_req_in;
  logic                 ind_wr_in;
  logic                 eng_busy_in;
  logic                 eng_done_in;
  logic [TIMEOUT_W-1:0] timeout_lim_in;
  logic                 err_clr_in;

  // Commands, grants and status from the arbiter
  logic                 start_xip_out;
  logic                 start_ind_out;
  logic                 ind_wr_out;
  logic                 break_seq_out;
  logic                 xip_gnt_out;
  logic                 ind_gnt_out;
  logic                 xip_ack_out;
  logic                 ind_ack_out;
  logic                 timeout_err_out;

  modport master (
    output xip_req_in, xip_break_in, ind_req_in, ind_wr_in,
           eng_busy_in, eng_done_in, timeout_lim_in, err_clr_in,
    input  start_xip_out, start_ind_out, ind_wr_out, break_seq_out,
           xip_gnt_out, ind_gnt_out, xip_ack_out, ind_ack_out,
           timeout_err_out
  );

  modport slave (
    input  xip_req_in, xip_break_in, ind_req_in, ind_wr_in,
           eng_busy_in, eng_done_in, timeout_lim_in, err_clr_in,
    output start_xip_out, start_ind_out, ind_wr_out, break_seq_out,
           xip_gnt_out, ind_gnt_out, xip_ack_out, ind_ack_out,
           timeout_err_out
  );

endinterface

// File: rtl/qspi_xfer_arbiter_wdog.sv
// Transfer watchdog: counts busy-owner cycles, fires when the count reaches
// limit-1 (limit 0 disables), and keeps a sticky error flag.
module qspi_arb_wdog #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 h_clk,
  input  logic                 h_rstn,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 err_clr,
  input  logic [TIMEOUT_W-1:0] lim,
  output logic                 fire,
  output logic                 err
);

  logic [TIMEOUT_W-1:0] cnt_q;

  // Limit is compared before the increment, so the counter never needs to wrap.
  assign fire = en && (lim != '0) && (cnt_q == (lim - TIMEOUT_W'(1)));

  // Cycle counter: cleared on entry to IDLE, saturates if the limit is disabled.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge h_clk) begin
    if (!h_rstn)                  cnt_q <= '0;
    else if (clr)                 cnt_q <= '0;
    else if (en && (cnt_q != '1)) cnt_q <= cnt_q + TIMEOUT_W'(1);
  end

  // Sticky timeout error; a firing timeout beats a simultaneous clear.
  always_ff @(posedge h_clk) begin
    if (!h_rstn)      err <= 1'b0;
    else if (fire)    err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

endmodule

// File: rtl/qspi_xfer_arbiter.sv
// Schedules the single QSPI engine between XIP reads and indirect transfers,
// issues one-cycle start/break commands, limits XIP streaks while indirect
// waits, and aborts hung transfers through the watchdog.
module qspi_xfer_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int TIMEOUT_W  = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic              h_clk,
  input  logic              h_rstn,
  qspi_xfer_arbiter_if.slave bus
);

  localparam int                  STARVE_W   = $clog2(STARVE_LIM + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

  arb_state_t          state_q, state_nx;
  logic [1:0]          owner_q, owner_nx;
  logic [STARVE_W-1:0] starve_q, starve_nx;
  logic                ind_wr_q, ind_wr_nx;
  logic                start_xip_q, start_ind_q;
  logic                brk, xip_ack, ind_ack;
  logic                wdog_fire, wdog_en, wdog_clr, timeout_err;

  // Watchdog runs whenever the engine is owned and restarts on every return to IDLE.
  assign wdog_en  = (state_q != ST_IDLE);
  assign wdog_clr = (state_nx == ST_IDLE);

  qspi_arb_wdog #(.TIMEOUT_W(TIMEOUT_W)) u_wdog (
    .h_clk   (h_clk),
    .h_rstn  (h_rstn),
    .en      (wdog_en),
    .clr     (wdog_clr),
    .err_clr (bus.err_clr_in),
    .lim     (bus.timeout_lim_in),
    .fire    (wdog_fire),
    .err     (timeout_err)
  );

  // Next-state, arbitration and pulse outputs.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_nx  = state_q;
    owner_nx  = owner_q;
    starve_nx = starve_q;
    ind_wr_nx = ind_wr_q;
    brk       = 1'b0;
    xip_ack   = 1'b0;
    ind_ack   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.ind_req_in && (!bus.xip_req_in || (starve_q == STARVE_MAX))) begin
          state_nx  = ST_IND_START;
          owner_nx  = OWN_IND;
          ind_wr_nx = bus.ind_wr_in;
          starve_nx = '0;
        end else if (bus.xip_req_in) begin
          state_nx = ST_XIP_START;
          owner_nx = OWN_XIP;
          if (bus.ind_req_in && (starve_q != STARVE_MAX))
            starve_nx = starve_q + STARVE_W'(1);
        end
      end
      ST_XIP_START: if (bus.eng_busy_in) state_nx = ST_XIP_ACT;
      ST_XIP_ACT: begin
        // done beats a same-cycle break
        if (bus.eng_done_in) begin
          xip_ack  = 1'b1;
          state_nx = ST_IDLE;
        end else if (bus.xip_break_in) begin
          brk      = 1'b1;
          state_nx = ST_ABORT;
        end
      end
      ST_IND_START: if (bus.eng_busy_in) state_nx = ST_IND_ACT;
      ST_IND_ACT: begin
        // breaks only apply to XIP sequences
        if (bus.eng_done_in) begin
          ind_ack  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_ABORT: if (!bus.eng_busy_in) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase

    // Watchdog overrides any done/break decided above.
    if (wdog_fire) begin
      state_nx = ST_IDLE;
      brk      = 1'b1;
      xip_ack  = 1'b0;
      ind_ack  = 1'b0;
    end

    if (state_nx == ST_IDLE) owner_nx = OWN_NONE;

    // A reset cycle abandons the transfer silently.
    if (!h_rstn) begin
      brk     = 1'b0;
      xip_ack = 1'b0;
      ind_ack = 1'b0;
    end
  end

  // State, owner, streak counter, latched direction and start pulses.
  always_ff @(posedge h_clk) begin
    if (!h_rstn) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      ind_wr_q    <= 1'b0;
      start_xip_q <= 1'b0;
      start_ind_q <= 1'b0;
    end else begin
      state_q     <= state_nx;
      owner_q     <= owner_nx;
      starve_q    <= starve_nx;
      ind_wr_q    <= ind_wr_nx;
      start_xip_q <= (state_q == ST_IDLE) && (state_nx == ST_XIP_START);
      start_ind_q <= (state_q == ST_IDLE) && (state_nx == ST_IND_START);
    end
  end

  assign bus.start_xip_out   = start_xip_q;
  assign bus.start_ind_out   = start_ind_q;
  assign bus.ind_wr_out      = ind_wr_q;
  assign bus.break_seq_out   = brk;
  assign bus.xip_gnt_out     = xip_owned(state_q, owner_q);
  assign bus.ind_gnt_out     = ind_owned(state_q);
  assign bus.xip_ack_out     = xip_ack;
  assign bus.ind_ack_out     = ind_ack;
  assign bus.timeout_err_out = timeout_err;

endmodule

// File: tb/tb_qspi_xfer_arbiter.sv
// Self-checking bench for qspi_xfer_arbiter: directed scenarios plus a
// randomized run, all compared each cycle against a transaction-level model.
module tb_qspi_xfer_arbiter;

  localparam int STARVE_LIM = 4;

  // Output vector bit positions
  localparam int O_SX = 8, O_SI = 7, O_WR = 6, O_BRK = 5, O_XG = 4,
                 O_IG = 3, O_XA = 2, O_IA = 1, O_ERR = 0;

  logic        h_clk = 1'b0;
  logic        h_rstn = 1'b0;
  logic        xip_req = 0, xip_break = 0, ind_req = 0, ind_wr = 0;
  logic        eng_busy = 0, eng_done = 0, err_clr = 0;
  logic [15:0] lim = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] obs;

  always #5 h_clk = ~h_clk;

  qspi_xfer_arbiter_if #(.TIMEOUT_W(16)) bus ();

  assign bus.xip_req_in     = xip_req;
  assign bus.xip_break_in   = xip_break;
  assign bus.ind_req_in     = ind_req;
  assign bus.ind_wr_in      = ind_wr;
  assign bus.eng_busy_in    = eng_busy;
  assign bus.eng_done_in    = eng_done;
  assign bus.timeout_lim_in = lim;
  assign bus.err_clr_in     = err_clr;

  qspi_xfer_arbiter #(.TIMEOUT_W(16), .STARVE_LIM(STARVE_LIM)) dut (
    .h_clk  (h_clk),
    .h_rstn (h_rstn),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, want);
    end
  endtask

  // Reference model: which requester owns the engine, the phase of its
  // transfer (0 wait busy, 1 active, 2 abort drain), and its age in cycles.
  int m_own = 0, m_ph = 0, m_age = 0, m_starve = 0;
  bit m_err = 0, m_wr = 0;

  function automatic bit model_timeout();
    return (m_own != 0) && (lim != 0) && (m_age == int'(lim) - 1);
  endfunction

  function automatic logic [8:0] model_expect();
    logic [8:0] e;
    bit tmo, act;
    tmo = model_timeout();
    act = (m_ph == 1) && !tmo;
    e = '0;
    e[O_SX]  = (m_own == 1) && (m_age == 0);
    e[O_SI]  = (m_own == 2) && (m_age == 0);
    e[O_WR]  = m_wr;
    e[O_BRK] = h_rstn && (tmo || ((m_own == 1) && act && !eng_done && xip_break));
    e[O_XG]  = (m_own == 1);
    e[O_IG]  = (m_own == 2);
    e[O_XA]  = h_rstn && (m_own == 1) && act && eng_done;
    e[O_IA]  = h_rstn && (m_own == 2) && act && eng_done;
    e[O_ERR] = m_err;
    return e;
  endfunction

  task automatic model_advance();
    bit tmo;
    tmo = model_timeout();
    if (!h_rstn) begin
      m_own = 0; m_ph = 0; m_age = 0; m_starve = 0; m_err = 0; m_wr = 0;
      return;
    end
    m_err = tmo ? 1'b1 : (err_clr ? 1'b0 : m_err);
    if (m_own == 0) begin
      if (ind_req && (!xip_req || m_starve == STARVE_LIM)) begin
        m_own = 2; m_ph = 0; m_age = 0; m_wr = ind_wr; m_starve = 0;
      end else if (xip_req) begin
        m_own = 1; m_ph = 0; m_age = 0;
        if (ind_req && m_starve < STARVE_LIM) m_starve++;
      end
    end else if (tmo) begin
      m_own = 0;
    end else begin
      m_age++;
      case (m_ph)
        0: if (eng_busy) m_ph = 1;
        1: if (eng_done) m_own = 0;
           else if (m_own == 1 && xip_break) m_ph = 2;
        default: if (!eng_busy) m_own = 0;
      endcase
    end
  endtask

  // One clock: sample at negedge, compare, advance the model, then return
  // 1 time unit after the posedge so the caller can drive the next inputs.
  task automatic step();
    @(negedge h_clk);
    obs = {bus.start_xip_out, bus.start_ind_out, bus.ind_wr_out, bus.break_seq_out,
           bus.xip_gnt_out, bus.ind_gnt_out, bus.xip_ack_out, bus.ind_ack_out,
           bus.timeout_err_out};
    check("outs", {23'd0, obs}, {23'd0, model_expect()});
    model_advance();
    @(posedge h_clk);
    #1;
  endtask

  task automatic clear_inputs();
    xip_req = 0; xip_break = 0; ind_req = 0; ind_wr = 0;
    eng_busy = 0; eng_done = 0; err_clr = 0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    h_rstn = 0;
    step();
    h_rstn = 1;
    step();
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_start, n_gnt, n_ack, n_brk, ack_cyc, brk_cyc, n_grants;
    logic [9:0] order;
    logic last_wr, wr_this;
    int ecnt;

    // ---------------- reset state ----------------
    reset_dut();
    check("reset_outs", {23'd0, obs}, 32'd0);

    // ---------------- XIP only ----------------
    xip_req = 1; step(); xip_req = 0;
    n_start = 0; n_gnt = 0; n_ack = 0; ack_cyc = -1;
    for (int c = 1; c <= 12; c++) begin
      eng_busy = (c >= 3) && (c <= 10);
      eng_done = (c == 10);
      step();
      n_start += obs[O_SX];
      n_gnt   += obs[O_XG];
      n_ack   += obs[O_XA];
      if (obs[O_XA]) ack_cyc = c;
    end
    check("xip_start_cnt", n_start, 1);
    check("xip_gnt_cycles", n_gnt, 10);
    check("xip_ack_cnt", n_ack, 1);
    check("xip_ack_cycle", ack_cyc, 10);
    check("xip_idle_after", obs[O_XG], 0);

    // ---------------- starvation order ----------------
    reset_dut();
    xip_req = 1; ind_req = 1; ind_wr = 1'($urandom);
    order = '0; n_grants = 0; ecnt = 0; last_wr = 0;
    for (int c = 0; c < 300 && n_grants < 10; c++) begin
      wr_this = ind_wr;
      step();
      if (obs[O_SX] || obs[O_SI]) begin
        if (obs[O_SI]) begin
          order[n_grants] = 1'b1;
          check("ind_wr_latch", obs[O_WR], last_wr);
        end
        n_grants++;
      end
      last_wr = wr_this;
      ind_wr  = 1'($urandom);
      // simple engine: busy after start, done 3 cycles later, then idle
      eng_done = 0;
      if (obs[O_SX] || obs[O_SI]) begin
        eng_busy = 1; ecnt = 3;
      end else if (eng_busy) begin
        if (ecnt == 0) eng_busy = 0;
        else begin
          ecnt--;
          if (ecnt == 0) eng_done = 1;
        end
      end
    end
    check("starve_grants", n_grants, 10);
    check("starve_order", {22'd0, order}, {22'd0, 10'b1000010000});

    // ---------------- XIP break ----------------
    reset_dut();
    xip_req = 1; step(); xip_req = 0;
    n_brk = 0; n_ack = 0;
    for (int c = 1; c <= 11; c++) begin
      eng_busy  = (c < 9);
      xip_break = (c == 6);
      step();
      n_brk += obs[O_BRK];
      n_ack += obs[O_XA];
      if (c == 9)  check("abort_gnt_held", obs[O_XG], 1);
      if (c == 10) check("abort_idle", obs[O_XG], 0);
    end
    xip_break = 0;
    check("break_cnt", n_brk, 1);
    check("break_no_ack", n_ack, 0);

    // ---------------- done and break together ----------------
    reset_dut();
    xip_req = 1; step(); xip_req = 0;
    for (int c = 1; c <= 8; c++) begin
      eng_busy  = (c < 7);
      eng_done  = (c == 6);
      xip_break = (c == 6);
      step();
      if (c == 6) begin
        check("done_brk_ack", obs[O_XA], 1);
        check("done_brk_nobrk", obs[O_BRK], 0);
      end
    end
    clear_inputs();

    // ---------------- watchdog, limit 20 ----------------
    reset_dut();
    lim = 16'd20;
    xip_req = 1; step(); xip_req = 0;
    eng_busy = 1; n_gnt = 0; brk_cyc = -1;
    for (int c = 1; c <= 40 && brk_cyc < 0; c++) begin
      step();
      n_gnt += obs[O_XG];
      if (obs[O_BRK]) brk_cyc = c;
    end
    check("wdog_fired_cycles", n_gnt, 20);
    step();
    check("wdog_err_set", obs[O_ERR], 1);
    check("wdog_idle", obs[O_XG], 0);
    eng_busy = 0; err_clr = 1; step(); err_clr = 0;
    step();
    check("wdog_err_clr", obs[O_ERR], 0);

    // ---------------- watchdog disabled ----------------
    lim = 16'd0;
    xip_req = 1; step(); xip_req = 0;
    eng_busy = 1; n_brk = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      n_brk += obs[O_BRK];
    end
    check("wdog_off_nobrk", n_brk, 0);
    check("wdog_off_err", obs[O_ERR], 0);
    check("wdog_off_gnt", obs[O_XG], 1);
    eng_done = 1; step(); eng_done = 0; eng_busy = 0;
    check("wdog_off_ack", obs[O_XA], 1);

    // ---------------- reset mid IND_ACT ----------------
    reset_dut();
    ind_req = 1; ind_wr = 1; step(); ind_req = 0;
    eng_busy = 1;
    for (int c = 0; c < 4; c++) step();
    check("ind_act_gnt", obs[O_IG], 1);
    h_rstn = 0; step();
    check("rst_cycle_nobrk", obs[O_BRK], 0);
    h_rstn = 1; eng_busy = 0; step();
    check("rst_outs", {23'd0, obs}, 32'd0);
    n_brk = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_brk += obs[O_BRK];
    end
    check("rst_no_brk", n_brk, 0);

    // ---------------- randomized run ----------------
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0)
        lim = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(6, 40));
      xip_req   = ($urandom_range(0, 9) < 6);
      ind_req   = ($urandom_range(0, 9) < 4);
      ind_wr    = 1'($urandom);
      xip_break = ($urandom_range(0, 7) == 0);
      eng_done  = ($urandom_range(0, 9) == 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) eng_busy = ~eng_busy;
      h_rstn    = ($urandom_range(0, 299) != 0);
      step();
    end
    h_rstn = 1;
    clear_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
